// File: rtl/exception_writeback_ctrl.sv
// Queues nonzero execute-stage exception codes and drains them into $rstatus
// on cycles the register-file write port is not used by normal writeback.
module exception_writeback_ctrl #(
    parameter int DEPTH   = 2,
    parameter int RSTATUS = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [2:0]  ex_code,
    input  logic        wb_busy,
    output logic        suppress_rd,
    output logic        rs_we,
    output logic [4:0]  rs_addr,
    output logic [31:0] rs_data,
    output logic        stall,
    output logic        exc_pending,
    output logic [7:0]  exc_count,
    output logic [2:0]  last_code
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     exc_count_q, exc_count_d;
    logic [2:0]     last_code_q, last_code_d;
    logic [2:0]     mem_q [DEPTH];
    logic           push, pop;

    assign stall       = (state_q == S_FULL);
    assign exc_pending = (state_q != S_IDLE);
    assign push        = ex_valid & ~stall & (ex_code != 3'd0);
    assign pop         = exc_pending & ~wb_busy;

    assign suppress_rd = push;
    assign rs_we       = pop;
    assign rs_addr     = 5'(RSTATUS);
    // Head is only meaningful when something is queued; no bypass from ex_code.
    assign rs_data     = exc_pending ? {29'd0, mem_q[rd_ptr_q]} : 32'd0;
    assign exc_count   = exc_count_q;
    assign last_code   = last_code_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        exc_count_d = exc_count_q;
        last_code_d = last_code_q;

        if (push) begin
            wr_ptr_d    = wr_ptr_q + AW'(1);
            last_code_d = ex_code;
            if (exc_count_q != 8'hFF) exc_count_d = exc_count_q + 8'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (push) state_d = S_PENDING;
            end
            S_PENDING: begin
                if (push && !pop && count_q == CW'(DEPTH - 1))
                    state_d = S_FULL;
                else if (pop && !push && count_q == CW'(1))
                    state_d = S_IDLE;
            end
            S_FULL: begin
                if (pop) state_d = S_PENDING;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            exc_count_q <= '0;
            last_code_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            exc_count_q <= exc_count_d;
            last_code_q <= last_code_d;
            if (push) mem_q[wr_ptr_q] <= ex_code;
        end
    end

endmodule

// File: tb/tb_exception_writeback_ctrl.sv
// Scoreboard bench for exception_writeback_ctrl: accepted codes are queued
// when driven and compared against rs_data whenever the port drains.
module tb_exception_writeback_ctrl;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [2:0]  ex_code;
    logic        wb_busy;
    logic        suppress_rd;
    logic        rs_we;
    logic [4:0]  rs_addr;
    logic [31:0] rs_data;
    logic        stall;
    logic        exc_pending;
    logic [7:0]  exc_count;
    logic [2:0]  last_code;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [2:0]  exp_q[$];
    int          m_exc_count = 0;
    logic [2:0]  m_last = 3'd0;

    exception_writeback_ctrl #(.DEPTH(DEPTH), .RSTATUS(30)) dut (
        .clock       (clock),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_code     (ex_code),
        .wb_busy     (wb_busy),
        .suppress_rd (suppress_rd),
        .rs_we       (rs_we),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .stall       (stall),
        .exc_pending (exc_pending),
        .exc_count   (exc_count),
        .last_code   (last_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: drive, check same-cycle outputs mid-cycle, update the model.
    task automatic step(input logic v, input logic [2:0] c, input logic b);
        logic m_full, m_push, m_pop;
        ex_valid = v;
        ex_code  = c;
        wb_busy  = b;
        @(negedge clock);
        m_full = (exp_q.size() == DEPTH);
        m_push = v && !m_full && (c != 3'd0);
        m_pop  = (exp_q.size() != 0) && !b;
        chk("suppress_rd", suppress_rd, m_push);
        chk("rs_we", rs_we, m_pop);
        chk("rs_data", rs_data, (exp_q.size() != 0) ? {29'd0, exp_q[0]} : 32'd0);
        chk("rs_addr", rs_addr, 32'd30);
        chk("stall", stall, m_full);
        chk("exc_pending", exc_pending, exp_q.size() != 0);
        chk("exc_count", exc_count, m_exc_count);
        chk("last_code", last_code, m_last);
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) begin
            exp_q.push_back(c);
            m_last = c;
            if (m_exc_count < 255) m_exc_count++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_pending"}, exc_pending, 1'b0);
        chk({tag, "_rs_we"}, rs_we, 1'b0);
        chk({tag, "_rs_data"}, rs_data, 32'd0);
        chk({tag, "_exc_count"}, exc_count, 8'd0);
        chk({tag, "_last_code"}, last_code, 3'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ex_valid = 1'b0;
        ex_code  = 3'd0;
        wb_busy  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_state("reset");
        chk("reset_suppress", suppress_rd, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;

        // single add overflow
        step(1, 3'd1, 0);
        step(0, 3'd0, 0);
        step(0, 3'd0, 0);

        // blocked port for three cycles
        step(1, 3'd2, 1);
        step(0, 3'd0, 1);
        step(0, 3'd0, 1);
        step(0, 3'd0, 1);
        step(0, 3'd0, 0);
        step(0, 3'd0, 0);

        // fill, stall, ignored third push, ordered drain
        step(1, 3'd3, 1);
        step(1, 3'd1, 1);
        step(1, 3'd2, 1);
        step(1, 3'd4, 0);
        step(0, 3'd0, 0);
        step(0, 3'd0, 0);

        // simultaneous push/pop at count 1
        step(1, 3'd1, 1);
        step(1, 3'd3, 0);
        step(0, 3'd0, 0);
        step(0, 3'd0, 0);

        // non-events
        step(1, 3'd0, 0);
        step(0, 3'd2, 0);
        step(0, 3'd7, 1);

        // random traffic, long enough to saturate exc_count
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
        chk("exc_count_saturated", exc_count, 8'd255);

        // asynchronous reset while full
        step(0, 3'd0, 0);
        step(0, 3'd0, 0);
        step(1, 3'd5, 1);
        step(1, 3'd6, 1);
        chk("full_before_reset", stall, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        exp_q.delete();
        m_exc_count = 0;
        m_last = 3'd0;
        @(posedge clock);
        #1 reset = 1'b0;
        step(1, 3'd1, 0);
        step(0, 3'd0, 0);
        step(0, 3'd0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
